shift_split: RTL and testbench

//  Receive-side inverse of the shift-concatenation packer. Accepts WIDTH-bit packed words
//  (first-packed bits at LSB) and hands variable-length fields of 1..WIDTH bits to a

---
 rtl/shift_split_if.sv | 30 +++
 rtl/shift_split.sv | 108 ++++++++++
 tb/tb_shift_split.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/shift_split_if.sv
// Bundle of word-input, field-request and field-output signals for the shift splitter.
// master = producer/consumer side (the bench), slave = the splitter itself.
interface shift_split_if #(
  parameter int WIDTH = 64
) ();
  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic [CW-1:0]    in_last_bits;
  logic             in_ready;
  logic             rd_en;
  logic [CW-1:0]    rd_bits;
  logic             rd_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    out_bits;
  logic             out_valid;
  logic             out_last;

  modport master (
    output in_data, in_valid, in_last, in_last_bits, rd_en, rd_bits,
    input  in_ready, rd_ready, out_data, out_bits, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, in_last, in_last_bits, rd_en, rd_bits,
    output in_ready, rd_ready, out_data, out_bits, out_valid, out_last
  );
endinterface

// File: rtl/shift_split.sv
// Shift splitter: unpacks LSB-first packed words into variable-length fields.
// A 2*WIDTH-bit buffer holds valid bits at the bottom; reads take bits from the
// LSB end while new words are appended just above the remaining valid bits.
module shift_split #(
  parameter int WIDTH = 64
) (
  input logic          clk,
  input logic          rst,
  shift_split_if.slave bus
);
  localparam int CW   = $clog2(WIDTH) + 1;
  localparam int CNTW = CW + 1;
  localparam logic [CNTW-1:0] WIDTH_C = CNTW'(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [2*WIDTH-1:0] sbuf;
  logic [CNTW-1:0]    count;
  logic [1:0]         state;

  logic               rd_bits_ok;
  logic               rd_fire;
  logic               wr_fire;
  logic [CNTW-1:0]    req;
  logic [CNTW-1:0]    last_ext;
  logic [CNTW-1:0]    n;
  logic [CNTW-1:0]    m;
  logic [CNTW-1:0]    rem;
  logic [CNTW-1:0]    count_next;
  logic [WIDTH-1:0]   word_mask;
  logic [WIDTH-1:0]   rd_mask;
  logic [2*WIDTH-1:0] buf_next;
  logic               drain_done;

  // Handshake decisions and the next buffer/count: read removal first, then word append.
  always_comb begin
    req        = {1'b0, bus.rd_bits};
    last_ext   = {1'b0, bus.in_last_bits};
    rd_bits_ok = (req != '0) && (req <= WIDTH_C);
    bus.rd_ready = rd_bits_ok &&
                   ((count >= req) || ((state == S_DRAIN) && (count != '0)));
    bus.in_ready = (state != S_DRAIN) && (count <= WIDTH_C);
    rd_fire    = bus.rd_en && bus.rd_ready;
    wr_fire    = bus.in_valid && bus.in_ready;

    // A final read may be shorter than requested when the message runs out.
    n = '0;
    if (rd_fire) begin
      n = (req < count) ? req : count;
    end
    rem        = count - n;
    drain_done = rd_fire && (state == S_DRAIN) && (rem == '0);

    // Zero last-bits means a full word; out-of-range values are clamped to a full word.
    m = WIDTH_C;
    if (bus.in_last && (last_ext != '0) && (last_ext <= WIDTH_C)) begin
      m = last_ext;
    end

    word_mask = {WIDTH{1'b1}} >> (WIDTH_C - m);
    rd_mask   = {WIDTH{1'b1}} >> (WIDTH_C - n);

    buf_next   = sbuf >> n;
    count_next = rem;
    if (wr_fire) begin
      buf_next   = buf_next | ({{WIDTH{1'b0}}, bus.in_data & word_mask} << rem);
      count_next = rem + m;
    end
  end

  // Buffer, bit count and message state; reset discards everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sbuf  <= '0;
      count <= '0;
      state <= S_IDLE;
    end else begin
      sbuf  <= buf_next;
      count <= count_next;
      if (wr_fire && bus.in_last) begin
        state <= S_DRAIN;
      end else if (wr_fire && (state == S_IDLE)) begin
        state <= S_RUN;
      end else if (drain_done) begin
        state <= S_IDLE;
      end
    end
  end

  // Registered field output, one cycle after the accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_data  <= '0;
      bus.out_bits  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
    end else begin
      bus.out_valid <= rd_fire;
      bus.out_last  <= drain_done;
      if (rd_fire) begin
        bus.out_data <= sbuf[WIDTH-1:0] & rd_mask;
        bus.out_bits <= n[CW-1:0];
      end
    end
  end
endmodule

// File: tb/tb_shift_split.sv
// Self-checking bench for shift_split. A bit-queue reference model tracks the
// message stream; every cycle compares the ready flags and any produced field.
module tb_shift_split;
  localparam int WIDTH = 64;
  localparam int CW    = $clog2(WIDTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  shift_split_if #(.WIDTH(WIDTH)) bus ();

  shift_split #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int assertCount = 0;
  int failCount   = 0;

  bit model_q[$];
  bit model_drain = 1'b0;

  logic [WIDTH-1:0] lastData;
  logic [WIDTH-1:0] lastBits;
  logic             lastLast;
  logic             lastValid;
  logic             lastInReady;

  // One comparison: counts it, and on mismatch counts a failure and reports it.
  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    assertCount++;
    assert (actual === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of inputs (called at posedge+1), checks the ready flags against
  // the model, updates the model, and checks the registered field after the edge.
  task automatic applyStimulus(input string tag, input bit wv, input logic [WIDTH-1:0] wdata,
                               input bit wlast, input int wlastbits, input bit re,
                               input int rbits);
    int sz;
    int n;
    int m;
    bit expIn;
    bit expRd;
    bit expLast;
    logic [WIDTH-1:0] expData;

    bus.in_valid     = wv;
    bus.in_data      = wdata;
    bus.in_last      = wlast;
    bus.in_last_bits = wlastbits[CW-1:0];
    bus.rd_en        = re;
    bus.rd_bits      = rbits[CW-1:0];
    #1;
    sz    = model_q.size();
    expIn = !model_drain && (sz <= WIDTH);
    expRd = (rbits >= 1) && (rbits <= WIDTH) && ((sz >= rbits) || (model_drain && sz != 0));
    lastInReady = bus.in_ready;
    checkOutput({tag, "_in_ready"}, bus.in_ready, expIn);
    checkOutput({tag, "_rd_ready"}, bus.rd_ready, expRd);

    expData = '0;
    expLast = 1'b0;
    n       = 0;
    if (re && expRd) begin
      n = (rbits < sz) ? rbits : sz;
      for (int i = 0; i < n; i++) expData[i] = model_q.pop_front();
      expLast = model_drain && (model_q.size() == 0);
      if (expLast) model_drain = 1'b0;
    end
    if (wv && expIn) begin
      m = (wlast && wlastbits != 0) ? wlastbits : WIDTH;
      for (int i = 0; i < m; i++) model_q.push_back(wdata[i]);
      if (wlast) model_drain = 1'b1;
    end

    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.rd_en    = 1'b0;
    lastValid = bus.out_valid;
    lastData  = bus.out_data;
    lastBits  = WIDTH'(bus.out_bits);
    lastLast  = bus.out_last;
    checkOutput({tag, "_out_valid"}, bus.out_valid, re && expRd);
    if (re && expRd) begin
      checkOutput({tag, "_out_data"}, bus.out_data, expData);
      checkOutput({tag, "_out_bits"}, WIDTH'(bus.out_bits), WIDTH'(n));
      checkOutput({tag, "_out_last"}, bus.out_last, expLast);
    end
  endtask

  // Empties whatever the model says is still buffered, using legal read lengths.
  task automatic flushModel(input string tag);
    for (int k = 0; k < 8 && model_q.size() > 0; k++) begin
      applyStimulus(tag, 1'b0, '0, 1'b0, 0, 1'b1,
                    (model_q.size() > WIDTH) ? WIDTH : model_q.size());
    end
  endtask

  // Directed scenarios followed by a random phase and a mid-message reset.
  initial begin
    bit sawLow;
    bit sawHigh;
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.in_last      = 1'b0;
    bus.in_last_bits = '0;
    bus.rd_en        = 1'b0;
    bus.rd_bits      = '0;

    // Reset state while reset is held.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", bus.out_valid, 1'b0);
    checkOutput("rst_out_data",  bus.out_data, '0);
    checkOutput("rst_out_bits",  WIDTH'(bus.out_bits), '0);
    checkOutput("rst_out_last",  bus.out_last, 1'b0);
    rst = 1'b0;
    applyStimulus("rst_idle", 1'b0, '0, 1'b0, 0, 1'b0, 1);

    // Scenario 1: nibble/byte extraction from one word.
    applyStimulus("t1_wr", 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, 0, 1'b0, 1);
    applyStimulus("t1_r0", 1'b0, '0, 1'b0, 0, 1'b1, 4);
    checkOutput("t1_r0_const", lastData, 64'hF);
    applyStimulus("t1_r1", 1'b0, '0, 1'b0, 0, 1'b1, 4);
    checkOutput("t1_r1_const", lastData, 64'hE);
    applyStimulus("t1_r2", 1'b0, '0, 1'b0, 0, 1'b1, 8);
    checkOutput("t1_r2_const", lastData, 64'hCD);
    checkOutput("t1_r2_bits", lastBits, 64'd8);
    flushModel("t1_flush");

    // Scenario 2: read straddling a word boundary.
    applyStimulus("t2_w0", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 1'b0, 1);
    applyStimulus("t2_w1", 1'b1, 64'h0, 1'b0, 0, 1'b0, 1);
    applyStimulus("t2_r60", 1'b0, '0, 1'b0, 0, 1'b1, 60);
    checkOutput("t2_r60_const", lastData, 64'h0FFF_FFFF_FFFF_FFFF);
    applyStimulus("t2_r8", 1'b0, '0, 1'b0, 0, 1'b1, 8);
    checkOutput("t2_r8_const", lastData, 64'h0F);
    bus.rd_bits = 7'd60;
    #1 checkOutput("t2_count_ge60", bus.rd_ready, 1'b1);
    bus.rd_bits = 7'd61;
    #1 checkOutput("t2_count_lt61", bus.rd_ready, 1'b0);
    flushModel("t2_flush");

    // Scenario 3: short final word, oversize final read.
    applyStimulus("t3_wr", 1'b1, 64'h1F, 1'b1, 5, 1'b0, 1);
    checkOutput("t3_blocked", bus.in_ready, 1'b0);
    applyStimulus("t3_rd", 1'b0, '0, 1'b0, 0, 1'b1, 8);
    checkOutput("t3_data", lastData, 64'h1F);
    checkOutput("t3_bits", lastBits, 64'd5);
    checkOutput("t3_last", lastLast, 1'b1);
    applyStimulus("t3_after", 1'b0, '0, 1'b0, 0, 1'b0, 1);
    checkOutput("t3_in_ready", lastInReady, 1'b1);

    // Scenario 4: continuous writes with 16-bit reads; in_ready must toggle.
    applyStimulus("t4_pre", 1'b1, {$urandom(), $urandom()}, 1'b0, 0, 1'b0, 1);
    sawLow  = 1'b0;
    sawHigh = 1'b0;
    for (int c = 0; c < 12; c++) begin
      applyStimulus("t4_run", 1'b1, {$urandom(), $urandom()}, 1'b0, 0, 1'b1, 16);
      if (lastInReady) sawHigh = 1'b1;
      else             sawLow  = 1'b1;
    end
    checkOutput("t4_toggle", sawLow && sawHigh, 1'b1);
    flushModel("t4_flush");

    // Scenario 5: illegal read lengths are ignored.
    applyStimulus("t5_wr", 1'b1, {$urandom(), $urandom()}, 1'b0, 0, 1'b0, 1);
    applyStimulus("t5_rd0", 1'b0, '0, 1'b0, 0, 1'b1, 0);
    applyStimulus("t5_rd65", 1'b0, '0, 1'b0, 0, 1'b1, 65);
    applyStimulus("t5_rd64", 1'b0, '0, 1'b0, 0, 1'b1, 64);

    // Random traffic against the model.
    for (int c = 0; c < 300; c++) begin
      applyStimulus("rnd", $urandom_range(0, 1) == 1, {$urandom(), $urandom()},
                    $urandom_range(0, 7) == 0, $urandom_range(0, WIDTH),
                    $urandom_range(0, 2) != 0,
                    ($urandom_range(0, 15) == 0) ? $urandom_range(0, WIDTH + 1)
                                                 : $urandom_range(1, WIDTH));
    end
    flushModel("rnd_flush");

    // Scenario 6: reset during DRAIN with 37 bits left and a field in flight.
    applyStimulus("t6_wr", 1'b1, {$urandom(), $urandom()}, 1'b1, 38, 1'b0, 1);
    applyStimulus("t6_rd", 1'b0, '0, 1'b0, 0, 1'b1, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_async_valid", bus.out_valid, 1'b0);
    checkOutput("t6_async_last",  bus.out_last, 1'b0);
    #2 rst = 1'b0;
    model_q.delete();
    model_drain = 1'b0;
    applyStimulus("t6_post", 1'b0, '0, 1'b0, 0, 1'b1, 1);
    checkOutput("t6_in_ready", lastInReady, 1'b1);
    applyStimulus("t6_refill", 1'b1, 64'hA5, 1'b1, 8, 1'b0, 1);
    applyStimulus("t6_reread", 1'b0, '0, 1'b0, 0, 1'b1, 8);
    checkOutput("t6_reread_data", lastData, 64'hA5);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
